seq_multiplier_32: RTL and testbench

Multi-cycle unsigned 32×32 shift-add multiplier producing a 64-bit product split into HI and LO words. Sits beside the bitwise logic units as an ALU execution unit; the ALU result stage reads `hi`/`lo` once `done` pulses. The same operand buses feed the AND/OR/adder units.

---
 rtl/seq_multiplier_32_if.sv | 24 ++
 rtl/seq_multiplier_32.sv | 97 +++++++++
 tb/tb_seq_multiplier_32.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_32_if.sv
// Operand/result bundle between the ALU issue logic and the shift-add multiplier.
interface seq_multiplier_32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Requester side: issues operands, reads back the product.
  modport master (
    output start, a, b,
    input  busy, done, hi, lo
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_multiplier_32.sv
// Unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per cycle.
// The product register P holds the partial sum in its upper half and the
// not-yet-consumed multiplier bits in its lower half; one extra top bit keeps
// the carry of each add until the following shift absorbs it.
module seq_multiplier_32 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_multiplier_32_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH:0]   p_added;
  logic [2*WIDTH:0]   p_shifted;

  // One shift-add step on the current product register.
  always_comb begin
    upper_sum = p_q[2*WIDTH:WIDTH];
    if (p_q[0]) begin
      upper_sum = p_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    end
    p_added   = {upper_sum, p_q[WIDTH-1:0]};
    p_shifted = p_added >> 1;
  end

  // Next-state and datapath control; DONE accepts a new start like IDLE.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          mcand_d = bus.a;
          p_d     = {{(WIDTH + 1){1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_shifted;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          hi_d    = p_shifted[2*WIDTH-1:WIDTH];
          lo_d    = p_shifted[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier_32.sv
// Self-checking bench for seq_multiplier_32 against a plain 64-bit product model.
module tb_seq_multiplier_32;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  seq_multiplier_32_if #(.WIDTH(32)) mif ();

  seq_multiplier_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: plain unsigned arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  // Issue one multiply from idle and wait (bounded) for done.
  task automatic do_mul(input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int busy_cnt, output logic overlap);
    mif.start = 1'b1;
    mif.a     = av;
    mif.b     = bv;
    @(posedge clk); #1;
    mif.start = 1'b0;
    lat      = 0;
    busy_cnt = mif.busy ? 1 : 0;
    overlap  = mif.busy & mif.done;
    while (!mif.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (mif.busy) busy_cnt++;
      if (mif.busy && mif.done) overlap = 1'b1;
    end
    if (!mif.done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mif.start = 1'b0; mif.a = '0; mif.b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({mif.busy, mif.done, mif.hi, mif.lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, required all zero",
               mif.busy, mif.done, mif.hi, mif.lo);
    end
  endtask

  task automatic test_basic();
    int lat, bc; logic ov;
    do_mul(32'd3, 32'd5, lat, bc, ov);
    vectors++;
    if (lat != 32) begin
      miscompares++; $display("FAIL basic_latency: got %0d required 32", lat);
    end
    vectors++;
    if (bc != 32 || ov) begin
      miscompares++; $display("FAIL basic_busy: busy cycles %0d overlap %b, required 32 and 0", bc, ov);
    end
    vectors++;
    if ({mif.hi, mif.lo} !== ref_mul(32'd3, 32'd5)) begin
      miscompares++; $display("FAIL basic_product: got %h%h required %h", mif.hi, mif.lo, ref_mul(32'd3, 32'd5));
    end
    @(posedge clk); #1;
    vectors++;
    if (mif.done !== 1'b0 || mif.busy !== 1'b0 || mif.lo !== 32'h0000000F) begin
      miscompares++; $display("FAIL basic_after_done: done=%b busy=%b lo=%h, required 0 0 0000000f",
                              mif.done, mif.busy, mif.lo);
    end
  endtask

  task automatic test_max();
    int lat, bc; logic ov;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, ov);
    vectors++;
    if (lat != 32 || mif.hi !== 32'hFFFF_FFFE || mif.lo !== 32'h0000_0001) begin
      miscompares++; $display("FAIL max_ones: lat=%0d hi=%h lo=%h, required 32 fffffffe 00000001", lat, mif.hi, mif.lo);
    end
    @(posedge clk); #1;
    do_mul(32'h8000_0000, 32'd2, lat, bc, ov);
    vectors++;
    if (lat != 32 || mif.hi !== 32'd1 || mif.lo !== 32'd0) begin
      miscompares++; $display("FAIL max_msb: lat=%0d hi=%h lo=%h, required 32 00000001 00000000", lat, mif.hi, mif.lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_ignored();
    int lat, bc; logic ov;
    logic [31:0] av, bv;
    logic [63:0] prev, got;
    int dones, done_at;
    do_mul(32'h1234_5678, 32'd0, lat, bc, ov);
    vectors++;
    if (lat != 32 || {mif.hi, mif.lo} !== 64'd0) begin
      miscompares++; $display("FAIL zero_operand: lat=%0d hi=%h lo=%h, required 32 0 0", lat, mif.hi, mif.lo);
    end
    @(posedge clk); #1;
    prev = {mif.hi, mif.lo};
    av = $urandom; bv = $urandom;
    mif.start = 1'b1; mif.a = av; mif.b = bv;
    @(posedge clk); #1;
    dones = 0; done_at = -1; got = '0;
    for (int i = 1; i <= 40; i++) begin
      mif.start = (i < 31) ? 1'($urandom_range(0, 1)) : 1'b0;
      mif.a = $urandom; mif.b = $urandom;
      @(posedge clk); #1;
      if (i == 10) begin
        vectors++;
        if ({mif.hi, mif.lo} !== prev) begin
          miscompares++; $display("FAIL hold_during_run: got %h%h required %h", mif.hi, mif.lo, prev);
        end
      end
      if (mif.done) begin
        dones++;
        done_at = i;
        got = {mif.hi, mif.lo};
      end
    end
    mif.start = 1'b0;
    vectors++;
    if (dones != 1 || done_at != 32) begin
      miscompares++; $display("FAIL ignored_start_done: %0d done pulses at %0d, required 1 at 32", dones, done_at);
    end
    vectors++;
    if (got !== ref_mul(av, bv)) begin
      miscompares++; $display("FAIL ignored_start_product: got %h required %h", got, ref_mul(av, bv));
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic ov;
    int dones;
    mif.start = 1'b1; mif.a = 32'h0001_0000; mif.b = 32'h0001_0000;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({mif.busy, mif.done, mif.hi, mif.lo} !== 66'd0) begin
      miscompares++; $display("FAIL reset_mid_state: busy=%b done=%b hi=%h lo=%h, required all zero",
                              mif.busy, mif.done, mif.hi, mif.lo);
    end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mif.done || mif.busy) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++; $display("FAIL reset_mid_no_done: %0d active cycles after abort, required 0", dones);
    end
    do_mul(32'h0001_0000, 32'h0001_0000, lat, bc, ov);
    vectors++;
    if (lat != 32 || mif.hi !== 32'd1 || mif.lo !== 32'd0) begin
      miscompares++; $display("FAIL reset_mid_fresh: lat=%0d hi=%h lo=%h, required 32 1 0", lat, mif.hi, mif.lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    mif.start = 1'b1; mif.a = 32'd7; mif.b = 32'd6;
    @(posedge clk); #1;
    mif.a = 32'h0000_FFFF; mif.b = 32'h0001_0001;
    cyc = 0;
    while (!mif.done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    vectors++;
    if (cyc != 32 || mif.hi !== 32'd0 || mif.lo !== 32'd42) begin
      miscompares++; $display("FAIL b2b_first: lat=%0d hi=%h lo=%h, required 32 0 0000002a", cyc, mif.hi, mif.lo);
    end
    @(posedge clk); #1;
    mif.start = 1'b0;
    vectors++;
    if (mif.busy !== 1'b1 || mif.done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_accept: busy=%b done=%b, required 1 0", mif.busy, mif.done);
    end
    cyc = 0;
    while (!mif.done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    vectors++;
    if (cyc != 32 || {mif.hi, mif.lo} !== ref_mul(32'h0000_FFFF, 32'h0001_0001)) begin
      miscompares++; $display("FAIL b2b_second: lat=%0d got %h%h required 32 %h", cyc, mif.hi, mif.lo,
                              ref_mul(32'h0000_FFFF, 32'h0001_0001));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_collision();
    logic [63:0] prev;
    prev = {mif.hi, mif.lo};
    rst = 1'b1; mif.start = 1'b1; mif.a = 32'd9; mif.b = 32'd9;
    @(posedge clk); #1;
    rst = 1'b0; mif.start = 1'b0;
    vectors++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || {mif.hi, mif.lo} !== 64'd0) begin
      miscompares++; $display("FAIL collision: busy=%b done=%b hi=%h lo=%h (was %h), required 0 0 0 0",
                              mif.busy, mif.done, mif.hi, mif.lo, prev);
    end
    @(posedge clk); #1;
    vectors++;
    if (mif.busy !== 1'b0) begin
      miscompares++; $display("FAIL collision_idle: busy=%b required 0", mif.busy);
    end
  endtask

  task automatic test_random();
    int lat, bc; logic ov;
    logic [31:0] av, bv;
    for (int n = 0; n < 12; n++) begin
      av = $urandom; bv = $urandom;
      if (n == 0) av = 32'hFFFF_FFFF;
      if (n == 1) bv = 32'h8000_0001;
      do_mul(av, bv, lat, bc, ov);
      vectors++;
      if (lat != 32 || bc != 32 || ov || {mif.hi, mif.lo} !== ref_mul(av, bv)) begin
        miscompares++; $display("FAIL random_%0d: %h*%h lat=%0d busy=%0d ov=%b got %h%h required %h",
                                n, av, bv, lat, bc, ov, mif.hi, mif.lo, ref_mul(av, bv));
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    mif.start = 1'b0; mif.a = '0; mif.b = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_max();
    test_zero_ignored();
    test_reset_mid();
    test_back_to_back();
    test_collision();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
